// File: rtl/parking_pkg.sv
// Shared definitions for the multi-lane parking controller: FSM states and width helpers.
package parking_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, OPEN, CLOSE} state_t;

    // Index width for a field addressing n values; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slots interleave as entry0, exit0, entry1, exit1, ...
    function automatic int slot_lane(input int slot);
        return slot / 2;
    endfunction

    function automatic logic slot_is_exit(input int slot);
        return (slot % 2) == 1;
    endfunction

endpackage

// File: rtl/parking_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module parking_rr_arbiter
    import parking_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         valid
);

    int idx;

    // Walk from farthest to nearest so the slot closest to ptr overwrites the rest.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant = W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_multilane_ctrl.sv
// Multi-lane parking controller sharing one occupancy counter across all gates.
// Optional per-lane bad-passcode lockout is enabled with `define PARKING_LOCKOUT_EN.
module parking_multilane_ctrl
    import parking_pkg::*;
#(
    parameter int           NUM_LANES      = 2,
    parameter int           MAX_COUNT      = 20,
    parameter int           COUNT_W        = 5,
    parameter logic [7:0]   PASSCODE       = 8'hFF,
    parameter int           OPEN_CYCLES    = 4,
    parameter int           FAIL_LIMIT     = 3,
    parameter int           LOCKOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_LANES-1:0]   enter_req,
    input  logic [NUM_LANES-1:0]   exit_req,
    input  logic [8*NUM_LANES-1:0] passcode_in,
    output logic [COUNT_W-1:0]     car_count,
    output logic                   lot_full,
    output logic [NUM_LANES-1:0]   entry_gate_open,
    output logic [NUM_LANES-1:0]   exit_gate_open,
    output logic [NUM_LANES-1:0]   entry_denied,
    output logic [NUM_LANES-1:0]   lane_locked
);

    localparam int SLOTS  = 2 * NUM_LANES;
    localparam int SLOT_W = idx_w(SLOTS);
    localparam int TMR_W  = idx_w(OPEN_CYCLES + 1);

    state_t               state, state_n;
    logic [SLOT_W-1:0]    slot, slot_n, ptr, ptr_n, grant;
    logic [TMR_W-1:0]     tmr, tmr_n;
    logic [COUNT_W-1:0]   count, count_n;
    logic [NUM_LANES-1:0] denied, denied_n, locked;
    logic [SLOTS-1:0]     req;
    logic                 grant_vld, code_ok, has_room;
    int                   lane;

    assign lane     = slot_lane(int'(slot));
    assign code_ok  = passcode_in[8*lane +: 8] == PASSCODE;
    assign has_room = count < COUNT_W'(MAX_COUNT);

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            req[2*i]   = enter_req[i] & ~locked[i];
            req[2*i+1] = exit_req[i];
        end
    end

    parking_rr_arbiter #(.N(SLOTS), .W(SLOT_W)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .valid (grant_vld)
    );

    always_comb begin
        state_n  = state;
        slot_n   = slot;
        ptr_n    = ptr;
        tmr_n    = tmr;
        count_n  = count;
        denied_n = '0;
        case (state)
            IDLE: if (grant_vld) begin
                slot_n  = grant;
                ptr_n   = (grant == SLOT_W'(SLOTS - 1)) ? '0 : grant + SLOT_W'(1);
                state_n = CHECK;
            end
            CHECK: begin
                state_n = IDLE;
                if (!slot_is_exit(int'(slot))) begin
                    if (code_ok && has_room) begin
                        count_n = count + COUNT_W'(1);
                        tmr_n   = TMR_W'(OPEN_CYCLES);
                        state_n = OPEN;
                    end else begin
                        denied_n[lane] = 1'b1;
                    end
                end else if (count != '0) begin
                    count_n = count - COUNT_W'(1);
                    tmr_n   = TMR_W'(OPEN_CYCLES);
                    state_n = OPEN;
                end
            end
            OPEN: begin
                tmr_n = tmr - TMR_W'(1);
                if (tmr <= TMR_W'(1)) state_n = CLOSE;
            end
            CLOSE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            slot   <= '0;
            ptr    <= '0;
            tmr    <= '0;
            count  <= '0;
            denied <= '0;
        end else begin
            state  <= state_n;
            slot   <= slot_n;
            ptr    <= ptr_n;
            tmr    <= tmr_n;
            count  <= count_n;
            denied <= denied_n;
        end
    end

    always_comb begin
        entry_gate_open = '0;
        exit_gate_open  = '0;
        if (state == OPEN) begin
            if (slot_is_exit(int'(slot))) exit_gate_open[lane]  = 1'b1;
            else                          entry_gate_open[lane] = 1'b1;
        end
    end

    assign car_count    = count;
    assign lot_full     = count == COUNT_W'(MAX_COUNT);
    assign entry_denied = denied;

`ifdef PARKING_LOCKOUT_EN
    localparam int FW = idx_w(FAIL_LIMIT + 1);
    localparam int LW = idx_w(LOCKOUT_CYCLES + 1);

    logic [NUM_LANES-1:0][FW-1:0] fail, fail_n;
    logic [NUM_LANES-1:0][LW-1:0] lock, lock_n;
    logic                         sel;

    // A full-lot refusal is neither a bad code nor a success, so it leaves the counter alone.
    always_comb begin
        fail_n = fail;
        lock_n = lock;
        sel    = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sel = (state == CHECK) && !slot_is_exit(int'(slot)) && (lane == i);
            if (lock[i] != '0) begin
                lock_n[i] = lock[i] - LW'(1);
                if (lock[i] == LW'(1)) fail_n[i] = '0;
            end else if (sel && !code_ok) begin
                if (int'(fail[i]) + 1 >= FAIL_LIMIT) begin
                    fail_n[i] = FW'(FAIL_LIMIT);
                    lock_n[i] = LW'(LOCKOUT_CYCLES);
                end else begin
                    fail_n[i] = fail[i] + FW'(1);
                end
            end else if (sel && has_room) begin
                fail_n[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fail <= '0;
            lock <= '0;
        end else begin
            fail <= fail_n;
            lock <= lock_n;
        end
    end

    always_comb begin
        locked = '0;
        for (int i = 0; i < NUM_LANES; i++) locked[i] = lock[i] != '0;
    end
`else
    assign locked = '0;
`endif

    assign lane_locked = locked;

endmodule

// File: tb/tb_parking_multilane_ctrl.sv
// Self-checking bench for parking_multilane_ctrl against a transaction-timeline reference model.
module tb_parking_multilane_ctrl;

    localparam int         NL    = 2;
    localparam int         MAXC  = 20;
    localparam int         OPEN  = 4;
    localparam int         FLIM  = 3;
    localparam int         LOCKC = 16;
    localparam logic [7:0] PC    = 8'hFF;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NL-1:0]   enter_req = '0, exit_req = '0;
    logic [8*NL-1:0] passcode_in = '0;
    logic [4:0]      car_count;
    logic            lot_full;
    logic [NL-1:0]   entry_gate_open, exit_gate_open, entry_denied, lane_locked;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parking_multilane_ctrl #(
        .NUM_LANES(NL), .MAX_COUNT(MAXC), .COUNT_W(5), .PASSCODE(PC),
        .OPEN_CYCLES(OPEN), .FAIL_LIMIT(FLIM), .LOCKOUT_CYCLES(LOCKC)
    ) dut (
        .clk(clk), .reset(reset), .enter_req(enter_req), .exit_req(exit_req),
        .passcode_in(passcode_in), .car_count(car_count), .lot_full(lot_full),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .entry_denied(entry_denied), .lane_locked(lane_locked)
    );

    // Reference model: each transaction is a scheduled timeline of edges.
    // en = number of rising edges seen; outputs after edge en are derived from the schedule.
    int en = 0, free_e = 0, chk_e = -1, chk_slot = 0;
    int g_lo = 0, g_hi = -1, g_slot = 0, d_e = -1, d_lane = 0;
    int m_ptr = 0, m_count = 0;
    int fails[NL];
    int l_lo[NL];
    int l_hi[NL];

    function automatic bit locked_at(input int lane, input int e);
`ifdef PARKING_LOCKOUT_EN
        return e >= l_lo[lane] && e <= l_hi[lane];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NL-1:0] exp_gate(input int dir);
        logic [NL-1:0] v = '0;
        if (en >= g_lo && en <= g_hi && g_slot % 2 == dir) v[g_slot/2] = 1'b1;
        return v;
    endfunction

    function automatic logic [NL-1:0] exp_denied();
        logic [NL-1:0] v = '0;
        if (d_e == en) v[d_lane] = 1'b1;
        return v;
    endfunction

    function automatic logic [NL-1:0] exp_locked();
        logic [NL-1:0] v = '0;
        for (int i = 0; i < NL; i++) v[i] = locked_at(i, en);
        return v;
    endfunction

    task automatic model_edge();
        int lane;
        bit r;
        en++;
        if (reset) begin
            free_e = en + 1; chk_e = -1; g_hi = -1; d_e = -1; m_ptr = 0; m_count = 0;
            for (int i = 0; i < NL; i++) begin fails[i] = 0; l_lo[i] = 0; l_hi[i] = -1; end
            return;
        end
        for (int i = 0; i < NL; i++) if (en == l_hi[i] + 1) fails[i] = 0;
        if (en == chk_e) begin
            chk_e = -1;
            lane = chk_slot / 2;
            free_e = en + 1;
            if (chk_slot % 2 == 0) begin
                if (passcode_in[8*lane +: 8] == PC && m_count < MAXC) begin
                    m_count++;
                    g_lo = en; g_hi = en + OPEN - 1; g_slot = chk_slot; free_e = en + OPEN + 2;
                    fails[lane] = 0;
                end else begin
                    d_e = en; d_lane = lane;
                    if (passcode_in[8*lane +: 8] != PC) begin
                        fails[lane]++;
                        if (fails[lane] == FLIM) begin l_lo[lane] = en; l_hi[lane] = en + LOCKC - 1; end
                    end
                end
            end else if (m_count > 0) begin
                m_count--;
                g_lo = en; g_hi = en + OPEN - 1; g_slot = chk_slot; free_e = en + OPEN + 2;
            end
        end else if (en >= free_e) begin
            for (int k = 0; k < 2 * NL; k++) begin
                int s;
                s = (m_ptr + k) % (2 * NL);
                r = (s % 2 == 1) ? exit_req[s/2] : (enter_req[s/2] && !locked_at(s/2, en - 1));
                if (r && chk_e == -1) begin
                    chk_slot = s; chk_e = en + 1; free_e = 1 << 30; m_ptr = (s + 1) % (2 * NL);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && !(chk_e == -1 && en + 1 >= free_e); k++) tick();
        checks++;
        if (!(chk_e == -1 && en + 1 >= free_e)) begin
            errors++;
            $display("FAIL wait_idle: controller still busy at edge %0d (free at %0d)", en, free_e);
        end
    endtask

    // One-cycle request on a slot; the passcode stays put for the check cycle.
    task automatic shot(input int slot, input logic [7:0] code);
        wait_idle();
        if (slot % 2 == 0) enter_req[slot/2] = 1'b1;
        else               exit_req[slot/2] = 1'b1;
        passcode_in[8*(slot/2) +: 8] = code;
        tick();
        enter_req = '0;
        exit_req  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (car_count !== 5'd0 || lot_full !== 1'b0 || entry_gate_open !== '0 ||
            exit_gate_open !== '0 || entry_denied !== '0 || lane_locked !== '0) begin
            errors++;
            $display("FAIL reset: count=%0d full=%b eg=%b xg=%b den=%b lk=%b, want all 0",
                     car_count, lot_full, entry_gate_open, exit_gate_open, entry_denied, lane_locked);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_entry();
        logic [NL-1:0] want_g;
        shot(0, PC);
        for (int k = 2; k <= 7; k++) begin
            tick();
            want_g = (k >= 2 && k <= 5) ? 2'b01 : 2'b00;
            checks++;
            if (entry_gate_open !== want_g || exit_gate_open !== '0 || car_count !== 5'd1) begin
                errors++;
                $display("FAIL single_entry t+%0d: gate=%b count=%0d, want gate=%b count=1",
                         k, entry_gate_open, car_count, want_g);
            end
        end
    endtask

    task automatic test_bad_code();
        shot(2, 8'h12);
        tick();
        checks++;
        if (entry_denied !== 2'b10 || entry_gate_open !== '0 || car_count !== 5'd1) begin
            errors++;
            $display("FAIL bad_code pulse: den=%b gate=%b count=%0d, want den=10 gate=00 count=1",
                     entry_denied, entry_gate_open, car_count);
        end
        tick();
        checks++;
        if (entry_denied !== 2'b00) begin
            errors++;
            $display("FAIL bad_code width: den=%b, want 00", entry_denied);
        end
    endtask

    task automatic test_fill();
        for (int n = 0; n < 40 && m_count < MAXC; n++) begin
            shot(0, PC);
            tick();
            checks++;
            if (car_count !== 5'(m_count)) begin
                errors++;
                $display("FAIL fill: count=%0d, want %0d", car_count, m_count);
            end
        end
        shot(0, PC);
        tick();
        checks++;
        if (entry_denied !== 2'b01 || lot_full !== 1'b1 || car_count !== 5'd20 || entry_gate_open !== '0) begin
            errors++;
            $display("FAIL full_deny: den=%b full=%b count=%0d, want den=01 full=1 count=20",
                     entry_denied, lot_full, car_count);
        end
        shot(1, PC);
        tick();
        checks++;
        if (exit_gate_open !== 2'b01 || car_count !== 5'd19 || lot_full !== 1'b0) begin
            errors++;
            $display("FAIL exit_after_full: xg=%b count=%0d full=%b, want xg=01 count=19 full=0",
                     exit_gate_open, car_count, lot_full);
        end
    endtask

    task automatic test_rr();
        int seq[$];
        logic [2*NL-1:0] prev, cur;
        int want[3] = '{0, 3, 0};
        do_reset();
        enter_req[0] = 1'b1;
        exit_req[1]  = 1'b1;
        passcode_in  = {NL{PC}};
        prev = '0;
        for (int k = 0; k < 60 && seq.size() < 3; k++) begin
            tick();
            cur = '0;
            for (int i = 0; i < NL; i++) begin
                cur[2*i]   = entry_gate_open[i];
                cur[2*i+1] = exit_gate_open[i];
            end
            if (cur != '0 && prev == '0)
                for (int s = 0; s < 2 * NL; s++) if (cur[s]) seq.push_back(s);
            prev = cur;
        end
        enter_req = '0;
        exit_req  = '0;
        checks++;
        if (seq.size() != 3) begin
            errors++;
            $display("FAIL rr_count: %0d grants seen, want 3", seq.size());
        end
        for (int i = 0; i < 3 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] != want[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: slot %0d, want %0d", i, seq[i], want[i]);
            end
        end
    endtask

    task automatic test_empty_exit_and_reset();
        do_reset();
        shot(3, PC);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (exit_gate_open !== '0 || entry_denied !== '0 || car_count !== 5'd0) begin
                errors++;
                $display("FAIL empty_exit: xg=%b den=%b count=%0d, want 0/0/0",
                         exit_gate_open, entry_denied, car_count);
            end
        end
        shot(0, PC);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (entry_gate_open !== '0 || exit_gate_open !== '0 || car_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_open: eg=%b xg=%b count=%0d, want 0/0/0",
                     entry_gate_open, exit_gate_open, car_count);
        end
    endtask

    task automatic test_lockout();
        int entry_hi = 0;
        logic [NL-1:0] want_lk;
        do_reset();
        shot(2, PC);
        for (int n = 0; n < FLIM; n++) begin
            shot(0, 8'h00);
            tick();
            checks++;
            if (entry_denied !== 2'b01) begin
                errors++;
                $display("FAIL lockout_deny[%0d]: den=%b, want 01", n, entry_denied);
            end
        end
`ifdef PARKING_LOCKOUT_EN
        want_lk = 2'b01;
`else
        want_lk = 2'b00;
`endif
        checks++;
        if (lane_locked !== want_lk) begin
            errors++;
            $display("FAIL lockout_set: locked=%b, want %b", lane_locked, want_lk);
        end
        enter_req[0] = 1'b1;
        exit_req[0]  = 1'b1;
        passcode_in[7:0] = PC;
        tick();
        exit_req[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (entry_gate_open[0]) entry_hi++;
            checks++;
            if (exit_gate_open !== exp_gate(1) || lane_locked !== exp_locked()) begin
                errors++;
                $display("FAIL lockout_exit: xg=%b lk=%b, want xg=%b lk=%b",
                         exit_gate_open, lane_locked, exp_gate(1), exp_locked());
            end
        end
        checks++;
`ifdef PARKING_LOCKOUT_EN
        if (entry_hi != 0) begin
            errors++;
            $display("FAIL lockout_mask: entry gate high %0d cycles while locked, want 0", entry_hi);
        end
`else
        if (entry_hi == 0) begin
            errors++;
            $display("FAIL no_lockout: entry gate never opened, want it served");
        end
`endif
        enter_req = '0;
        for (int k = 0; k < 12; k++) tick();
        checks++;
        if (lane_locked !== '0) begin
            errors++;
            $display("FAIL lockout_expire: locked=%b, want 00", lane_locked);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            enter_req = NL'($urandom);
            exit_req  = NL'($urandom);
            for (int i = 0; i < NL; i++)
                passcode_in[8*i +: 8] = ($urandom_range(0, 9) < 7) ? PC : 8'($urandom);
            tick();
            checks++;
            if (car_count !== 5'(m_count) || lot_full !== (m_count == MAXC) ||
                entry_gate_open !== exp_gate(0) || exit_gate_open !== exp_gate(1) ||
                entry_denied !== exp_denied() || lane_locked !== exp_locked() ||
                $countones({entry_gate_open, exit_gate_open}) > 1) begin
                errors++;
                $display("FAIL random@%0d: count=%0d/%0d eg=%b/%b xg=%b/%b den=%b/%b lk=%b/%b",
                         en, car_count, m_count, entry_gate_open, exp_gate(0), exit_gate_open,
                         exp_gate(1), entry_denied, exp_denied(), lane_locked, exp_locked());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin fails[i] = 0; l_lo[i] = 0; l_hi[i] = -1; end
        test_reset();
        test_single_entry();
        test_bad_code();
        test_fill();
        test_rr();
        test_empty_exit_and_reset();
        test_lockout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
